// File: rtl/dmem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid data port: a word-addressed SRAM
// with byte-enabled writes, fixed-latency in-order responses and a cap on outstanding requests.
module dmem_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          INTG_EN         = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] SPAN  = 33'(4 * DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             addr_err;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W:0]   in_use;

  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_rdata [LATENCY];

  // Decode: misaligned or out-of-window addresses never touch the array.
  assign offset   = data_addr_i - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign addr_err = (data_addr_i[1:0] != 2'b00) || (data_addr_i < BASE_ADDR) ||
                    ({1'b0, offset} >= SPAN);

  // A response leaving this cycle frees its slot for a grant in the same cycle.
  assign in_use     = {1'b0, outstanding} - {{CNT_W{1'b0}}, data_rvalid_o};
  assign data_gnt_o = data_req_i & ~stall_i & ~rst_i &
                      (in_use < (CNT_W + 1)'(MAX_OUTSTANDING));

  // NOTE: the array has no reset; contents survive rst_i so it maps onto plain SRAM.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && !addr_err) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) mem[word_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the read of mem below therefore sees the word as it was before this edge's write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid  <= '0;
      pipe_err    <= '0;
      outstanding <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_rdata[i] <= '0;
    end else begin
      pipe_valid[0] <= data_gnt_o;
      pipe_err[0]   <= data_gnt_o & addr_err;
      pipe_rdata[0] <= (data_gnt_o && !data_we_i && !addr_err) ? mem[word_idx] : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
      case ({data_gnt_o, data_rvalid_o})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Non-valid stages are loaded with zero data, so rdata/err are already 0 when idle.
  assign data_rvalid_o = pipe_valid[LATENCY-1];
  assign data_err_o    = pipe_err[LATENCY-1];
  assign data_rdata_o  = pipe_rdata[LATENCY-1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_rdata_intg_o = '0;
    if (INTG_EN) begin
      for (int n = 0; n < 4; n++) data_rdata_intg_o[n] = ^data_rdata_o[8*n +: 8];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{data_wdata_intg_i, offset[31:IDX_W+2], offset[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=1 instance for data/error paths and a
// LATENCY=3, MAX_OUTSTANDING=2 instance for throttling, stall and mid-operation reset.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, stall, req, we, gnt, rvalid, err;
  logic [1:0][3:0]  be;
  logic [1:0][6:0]  wintg, rintg;
  logic [1:0][31:0] addr, wdata, rdata;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTSTANDING(2), .INTG_EN(1'b1))
  u_lat1 (
    .clk_i(clk), .rst_i(rst[0]), .stall_i(stall[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_wdata_intg_i(wintg[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_rdata_intg_o(rintg[0]), .data_err_o(err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(2), .INTG_EN(1'b1))
  u_lat3 (
    .clk_i(clk), .rst_i(rst[1]), .stall_i(stall[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_wdata_intg_i(wintg[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_rdata_intg_o(rintg[1]), .data_err_o(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Even parity per byte, counted bit by bit.
  function automatic logic [6:0] parity_of(input logic [31:0] w);
    logic [6:0] p = '0;
    for (int b = 0; b < 4; b++) begin
      int ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(w[8*b + k]);
      p[b] = (ones % 2) != 0;
    end
    return p;
  endfunction

  task automatic push(input int s, input logic [31:0] r, input logic e, input int due);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.due   = due;
    if (s == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   depth = (s == 0) ? q0.size() : q1.size();
    if (rvalid[s]) begin
      if (depth == 0) begin
        check($sformatf("d%0d_unexpected_rvalid", s), 32'd1, 32'd0);
      end else begin
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("d%0d_rvalid_cycle", s), 32'(cyc), 32'(e.due));
        check($sformatf("d%0d_rdata", s), rdata[s], e.rdata);
        check($sformatf("d%0d_err", s), 32'(err[s]), 32'(e.err));
        check($sformatf("d%0d_intg", s), 32'(rintg[s]), 32'(parity_of(e.rdata)));
      end
    end else begin
      check($sformatf("d%0d_idle_rdata", s), rdata[s], 32'h0);
      check($sformatf("d%0d_idle_err", s), 32'(err[s]), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  // Called at posedge+1; holds req until granted, returns at posedge+1 after the grant edge.
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rdata, input logic exp_err);
    bit granted = 1'b0;
    we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b; req[s] = 1'b1;
    for (int t = 0; t < 20 && !granted; t++) begin
      @(negedge clk);
      if (gnt[s]) begin
        push(s, exp_rdata, exp_err, cyc + lat(s));
        granted = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!granted) check($sformatf("d%0d_gnt_timeout", s), 32'd0, 32'd1);
    req[s] = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    int         n;
    rst = 2'b11; req = 2'b11; stall = '0; we = '0; be = '0;
    addr = {BASE, BASE}; wdata = '0; wintg = '0;

    // Reset held two cycles with requests pending
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_gnt0", 32'(gnt[0]), 32'd0);
      check("rst_gnt1", 32'(gnt[1]), 32'd0);
      check("rst_rvalid0", 32'(rvalid[0]), 32'd0);
      check("rst_rvalid1", 32'(rvalid[1]), 32'd0);
      check("rst_outstanding0", 32'(u_lat1.outstanding), 32'd0);
      check("rst_outstanding1", 32'(u_lat3.outstanding), 32'd0);
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = '0; req = '0;

    // Store/load, read-after-write in consecutive cycles
    issue(0, 1'b1, BASE + 32'h00, 32'h0123_4567, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    // Byte enables; be ignored on reads; be=0 write is a no-op
    issue(0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    issue(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    issue(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    issue(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);
    // Decode errors, then confirm nothing was written
    issue(0, 1'b0, BASE + 32'h2, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b1, TOP, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b1, BASE + 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, BASE - 32'h4, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, TOP, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 32'h0123_4567, 1'b0);
    // Last word in the window
    issue(0, 1'b1, TOP - 32'h4, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, TOP - 32'h4, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);

    // Throttle on the LATENCY=3 instance with req held high
    pat = 6'b011011;
    n = 0;
    we[1] = 1'b1; be[1] = 4'hF; req[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr[1]  = BASE + 32'(4 * n);
      wdata[1] = 32'h100 + 32'(n);
      @(negedge clk);
      check($sformatf("throttle_gnt%0d", i), 32'(gnt[1]), 32'(pat[i]));
      if (gnt[1]) begin
        push(1, 32'h0, 1'b0, cyc + 3);
        n++;
      end
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++)
      issue(1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, 32'h100 + 32'(i), 1'b0);

    // Stall blocks grants but not the response already in flight
    issue(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h102, 1'b0);
    stall[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_gnt%0d", i), 32'(gnt[1]), 32'd0);
      @(posedge clk); #1;
    end
    stall[1] = 1'b0; req[1] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Reset with a response in flight: it is dropped; grant allowed as reset falls
    issue(1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, 32'h101, 1'b0);
    q1.delete();
    rst[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE + 32'hC;
    @(negedge clk);
    check("midrst_gnt", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    check("postrst_outstanding", 32'(u_lat3.outstanding), 32'd0);
    check("postrst_gnt", 32'(gnt[1]), 32'd1);
    if (gnt[1]) push(1, 32'h103, 1'b0, cyc + 3);
    @(posedge clk); #1;
    req[1] = 1'b0;

    for (int t = 0; t < 50 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
